bit_count_unit: RTL
===================

Name: bit_count_unit

Overview:
- Multi-cycle bit-counting unit for the E stage: population count (ones/zeros) and leading-ones/leading-zeros (CLO/CLZ) on a WIDTH-bit operand.
- Processes BPC bits per clock, MSB first, with a start/busy/done handshake so the hazard unit can stall on busy, as it does for the multiply/divide unit.
- Generalises the single-mode 32-bit combinational counter: parametrised width and throughput, four modes, and an abort input for exception/interrupt flush.

Parameters:
- WIDTH, 32, operand width in bits; must be at least 1.
- BPC, 4, bits consumed per RUN cycle; must divide WIDTH exactly, otherwise elaboration fails via a generate-time error.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- mode  input  2  00 count ones, 01 count zeros, 10 count leading zeros, 11 count leading ones; latched with start
- A  input  WIDTH  operand; latched with start
- abort  input  1  flush the in-flight operation (exception/eret)
- busy  output  1  high while an operation is in RUN
- done  output  1  one-cycle pulse: cnt is valid for the just-finished operation
- cnt  output  32  result, zero-extended; holds until the next completion or reset

Behaviour:
- Reset (synchronous, active-high, at a rising edge): state IDLE, busy=0, done=0, cnt=0, internal shift register, chunk counter and leading flag cleared. Reset overrides start and abort.
- States: IDLE, RUN, DONE. busy=1 exactly in RUN; done=1 exactly in DONE. Both are registered state decodes with no combinational path from inputs.
- IDLE --start--> RUN: the edge latches A into the shift register and mode into a mode register, clears the accumulator, sets the leading flag to 1, and sets the chunk counter to 0.
- RUN, each edge:
  - Take the top BPC bits of the shift register, then shift left by BPC.
  - Mode 00: accumulator += number of 1s in the chunk.
  - Mode 01: accumulator += number of 0s in the chunk.
  - Modes 10/11: if the leading flag is set, add the count of consecutive target bits from the chunk MSB down to the first mismatch. Target is 0 for mode 10 and 1 for mode 11. If a mismatch is found in the chunk, clear the leading flag. If the flag is already clear, add 0.
  - Increment the chunk counter. On the last chunk (counter = WIDTH/BPC-1), write the final sum, including the last chunk, to cnt and go to DONE.
- Latency: start sampled at edge T, busy=1 for WIDTH/BPC cycles (edges T+1 .. T+WIDTH/BPC), done=1 for the single cycle after edge T+WIDTH/BPC. Latency is fixed regardless of data: no early exit in leading modes.
- DONE lasts one cycle, then returns to IDLE. If start=1 in DONE, go directly to RUN, latching new A/mode. This gives back-to-back throughput of one operation per WIDTH/BPC+1 cycles.
- start in RUN is ignored: no queuing, and the latched operands are unaffected.
- A and mode may change freely after the start edge.
- abort=1 in RUN: next state IDLE, busy drops next cycle, no done pulse, cnt keeps its previous value. abort in IDLE or DONE has no effect on state; a DONE pulse already visible is not retracted. abort and start in the same IDLE cycle: abort wins and the operation is not launched.
- Width rules:
  - The accumulator is clog2(WIDTH+1) bits, so the maximum value WIDTH is representable (e.g. 32 needs 6 bits).
  - cnt is zero-extended to 32 bits. WIDTH > 2^32-1 is not supported.
- Boundary values: all-zero operand gives ones=0, zeros=WIDTH, CLZ=WIDTH, CLO=0. All-ones operand gives the mirror values. With WIDTH=BPC there is a single RUN cycle.

Test Plan:
- WIDTH=32, BPC=4, A=33 (0x00000021), each mode in turn -> cnt = 2 (mode 00), 30 (mode 01), 26 (mode 10), 0 (mode 11). For each: busy high exactly 8 cycles, then a done pulse of exactly 1 cycle.
- A=0x00000000 and A=0xFFFFFFFF in modes 10/11 -> CLZ=32/CLO=0 and CLZ=0/CLO=32 respectively; the 6-bit accumulator does not overflow.
- Back-to-back: first op A=0xF0000000, mode 11 (CLO=4); hold start=1 during DONE with second op A=0x0000FFFF, mode 10 -> first cnt=4 with done, then busy next cycle, second cnt=16 exactly 9 cycles later.
- Mid-op disruption:
  - Assert abort in the 3rd RUN cycle -> busy low next cycle, no done, cnt retains the prior result 16.
  - Assert reset mid-RUN -> all outputs 0 the next cycle.
- start pulsed during RUN with a different A -> ignored; result matches the originally latched operand.
- Re-parametrise WIDTH=8, BPC=8, A=0x21 -> busy for exactly 1 cycle, cnt=2 (mode 00) and cnt=2 (mode 10).

Source files
------------

// File: rtl/bit_count_unit.sv
// rtl/bit_count_unit.sv - multi-cycle popcount / leading-zero / leading-one counter
module bit_count_unit #(
    parameter int WIDTH = 32,
    parameter int BPC   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] A,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [31:0]      cnt
);
    localparam int NCH = WIDTH / BPC;
    localparam int AW  = $clog2(WIDTH + 1);
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    generate
        if (WIDTH < 1 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_param
            $error("bit_count_unit: BPC must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [1:0]       mode_q, mode_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    chunk_q, chunk_d;
    logic             lead_q, lead_d;
    logic [31:0]      cnt_q, cnt_d;

    logic [BPC-1:0]   chunk;
    logic [AW-1:0]    ones, zeros, lead_len, add;
    logic             hit;

    assign chunk = sr_q[WIDTH-1 -: BPC];

    // Per-chunk counts; hit marks the first bit (from chunk MSB) that breaks the leading run.
    always_comb begin
        ones     = '0;
        lead_len = '0;
        hit      = 1'b0;
        for (int i = BPC - 1; i >= 0; i--) begin
            ones = ones + AW'(chunk[i]);
            if (!hit) begin
                if (chunk[i] == mode_q[0]) lead_len = lead_len + AW'(1);
                else                       hit      = 1'b1;
            end
        end
        zeros = AW'(BPC) - ones;
        case (mode_q)
            2'b00:   add = ones;
            2'b01:   add = zeros;
            default: add = lead_q ? lead_len : '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        chunk_d = chunk_q;
        lead_d  = lead_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) state_d = S_IDLE;
                if (start && !abort) begin
                    state_d = S_RUN;
                    sr_d    = A;
                    mode_d  = mode;
                    acc_d   = '0;
                    lead_d  = 1'b1;
                    chunk_d = '0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    sr_d    = sr_q << BPC;
                    acc_d   = acc_q + add;
                    lead_d  = lead_q & ~hit;
                    chunk_d = chunk_q + CW'(1);
                    if (chunk_q == CW'(NCH - 1)) begin
                        cnt_d   = 32'(acc_q + add);
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            mode_q  <= '0;
            acc_q   <= '0;
            chunk_q <= '0;
            lead_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            chunk_q <= chunk_d;
            lead_q  <= lead_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign cnt  = cnt_q;
endmodule
